// File: rtl/div_rs_ctrl_if.sv
// rtl/div_rs_ctrl_if.sv - dispatch, CDB and divider signals of the divide reservation station
interface div_rs_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          disp_valid;
    logic          disp_ready;
    logic [2:0]    disp_funct3;
    logic [5:0]    disp_tag;
    logic [31:0]   disp_v1;
    logic [31:0]   disp_v2;
    logic [5:0]    disp_q1;
    logic [5:0]    disp_q2;
    logic          disp_rdy1;
    logic          disp_rdy2;
    logic          cdb_valid;
    logic [5:0]    cdb_tag;
    logic [31:0]   cdb_data;
    logic          div_queue_en;
    logic [31:0]   div_op1;
    logic [31:0]   div_op2;
    logic [2:0]    div_funct3;
    logic [5:0]    div_tag;
    logic          div_busy;
    logic [CW-1:0] count;

    modport slave (
        input  disp_valid, disp_funct3, disp_tag, disp_v1, disp_v2, disp_q1, disp_q2,
               disp_rdy1, disp_rdy2, cdb_valid, cdb_tag, cdb_data, div_busy,
        output disp_ready, div_queue_en, div_op1, div_op2, div_funct3, div_tag, count
    );

    modport master (
        output disp_valid, disp_funct3, disp_tag, disp_v1, disp_v2, disp_q1, disp_q2,
               disp_rdy1, disp_rdy2, cdb_valid, cdb_tag, cdb_data, div_busy,
        input  disp_ready, div_queue_en, div_op1, div_op2, div_funct3, div_tag, count
    );
endinterface

// File: rtl/div_rs_ctrl.sv
// rtl/div_rs_ctrl.sv - divide reservation station: compacting entry queue, CDB wakeup, issue sequencer
module div_rs_ctrl #(
    parameter int DEPTH   = 4,
    parameter int DIV_LAT = 5
) (
    input  logic         clk,
    input  logic         rst,
    div_rs_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [LW-1:0] LAT_C   = LW'(DIV_LAT);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    logic [DEPTH-1:0] val_q, val_d, r1_q, r1_d, r2_q, r2_d;
    logic [2:0]       f3_q  [DEPTH];
    logic [2:0]       f3_d  [DEPTH];
    logic [5:0]       tag_q [DEPTH];
    logic [5:0]       tag_d [DEPTH];
    logic [5:0]       q1_q  [DEPTH];
    logic [5:0]       q1_d  [DEPTH];
    logic [5:0]       q2_q  [DEPTH];
    logic [5:0]       q2_d  [DEPTH];
    logic [31:0]      v1_q  [DEPTH];
    logic [31:0]      v1_d  [DEPTH];
    logic [31:0]      v2_q  [DEPTH];
    logic [31:0]      v2_d  [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    state_t           state_q;
    logic [LW-1:0]    cnt_q;
    logic             qen_q;
    logic [31:0]      op1_q, op2_q;
    logic [2:0]       f3o_q;
    logic [5:0]       tago_q;

    logic             issue, alloc, cdb_hit;
    int               sel;
    logic [31:0]      sel_v1, sel_v2;
    logic [2:0]       sel_f3;
    logic [5:0]       sel_tag;

    // Ready is judged on registered rdy bits only, so a wakeup becomes eligible next cycle.
    assign cdb_hit = bus.cdb_valid && (bus.cdb_tag != 6'd0);
    assign alloc   = bus.disp_valid && (count_q < DEPTH_C);

    always_comb begin
        sel   = 0;
        issue = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (val_q[i] && r1_q[i] && r2_q[i]) begin
                sel   = i;
                issue = (state_q == ST_IDLE) && !bus.div_busy;
            end
        end
        sel_v1  = '0;
        sel_v2  = '0;
        sel_f3  = '0;
        sel_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == sel) begin
                sel_v1  = v1_q[i];
                sel_v2  = v2_q[i];
                sel_f3  = f3_q[i];
                sel_tag = tag_q[i];
            end
        end
    end

    always_comb begin
        int wr;
        wr    = int'(count_q) - (issue ? 1 : 0);
        val_d = val_q;
        r1_d  = r1_q;
        r2_d  = r2_q;
        f3_d  = f3_q;
        tag_d = tag_q;
        q1_d  = q1_q;
        q2_d  = q2_q;
        v1_d  = v1_q;
        v2_d  = v2_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue && i >= sel) begin
                val_d[i] = val_q[i+1];
                r1_d[i]  = r1_q[i+1];
                r2_d[i]  = r2_q[i+1];
                f3_d[i]  = f3_q[i+1];
                tag_d[i] = tag_q[i+1];
                q1_d[i]  = q1_q[i+1];
                q2_d[i]  = q2_q[i+1];
                v1_d[i]  = v1_q[i+1];
                v2_d[i]  = v2_q[i+1];
            end
        end
        if (issue) begin
            val_d[DEPTH-1] = 1'b0;
            r1_d[DEPTH-1]  = 1'b0;
            r2_d[DEPTH-1]  = 1'b0;
        end
        // Wakeup acts on the shifted copies; the new op lands on the first free slot after compaction.
        for (int i = 0; i < DEPTH; i++) begin
            if (val_d[i] && !r1_d[i] && cdb_hit && q1_d[i] == bus.cdb_tag) begin
                v1_d[i] = bus.cdb_data;
                r1_d[i] = 1'b1;
            end
            if (val_d[i] && !r2_d[i] && cdb_hit && q2_d[i] == bus.cdb_tag) begin
                v2_d[i] = bus.cdb_data;
                r2_d[i] = 1'b1;
            end
            if (alloc && i == wr) begin
                val_d[i] = 1'b1;
                f3_d[i]  = bus.disp_funct3;
                tag_d[i] = bus.disp_tag;
                q1_d[i]  = bus.disp_q1;
                q2_d[i]  = bus.disp_q2;
                r1_d[i]  = bus.disp_rdy1 || (cdb_hit && bus.disp_q1 == bus.cdb_tag);
                r2_d[i]  = bus.disp_rdy2 || (cdb_hit && bus.disp_q2 == bus.cdb_tag);
                v1_d[i]  = bus.disp_rdy1 ? bus.disp_v1 : bus.cdb_data;
                v2_d[i]  = bus.disp_rdy2 ? bus.disp_v2 : bus.cdb_data;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (alloc && !issue) begin
            count_d = count_q + 1'b1;
        end else if (issue && !alloc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                f3_q[i]  <= '0;
                tag_q[i] <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
            end
        end else begin
            val_q   <= val_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            count_q <= count_d;
            f3_q    <= f3_d;
            tag_q   <= tag_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
        end
    end

    // Operand lines load only on issue, so they stay valid through the divider's result state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            qen_q   <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            f3o_q   <= '0;
            tago_q  <= '0;
        end else begin
            qen_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q <= ST_RUN;
                        cnt_q   <= LAT_C;
                        qen_q   <= 1'b1;
                        op1_q   <= sel_v1;
                        op2_q   <= sel_v2;
                        f3o_q   <= sel_f3;
                        tago_q  <= sel_tag;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == LW'(1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.disp_ready   = (count_q < DEPTH_C);
    assign bus.count        = count_q;
    assign bus.div_queue_en = qen_q;
    assign bus.div_op1      = op1_q;
    assign bus.div_op2      = op2_q;
    assign bus.div_funct3   = f3o_q;
    assign bus.div_tag      = tago_q;
endmodule

// File: tb/tb_div_rs_ctrl.sv
// tb/tb_div_rs_ctrl.sv - self-checking bench for div_rs_ctrl with a behavioural divider and queue model
module tb_div_rs_ctrl;
    localparam int DEPTH   = 4;
    localparam int DIV_LAT = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_rs_ctrl_if #(.DEPTH(DEPTH)) bus();
    div_rs_ctrl #(.DEPTH(DEPTH), .DIV_LAT(DIV_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Divider: states 1..DIV_LAT after an accepted strobe, busy except in idle and result state.
    int dstate;
    always @(posedge clk or posedge rst) begin
        if (rst)                   dstate <= 0;
        else if (dstate == 0)      dstate <= bus.div_queue_en ? 1 : 0;
        else if (dstate == DIV_LAT) dstate <= 0;
        else                       dstate <= dstate + 1;
    end
    assign bus.div_busy = (dstate >= 1) && (dstate < DIV_LAT);

    function automatic logic [31:0] div_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd4:    div_ref = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
            3'd5:    div_ref = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6:    div_ref = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
            default: div_ref = (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.disp_valid = 0; bus.disp_funct3 = 0; bus.disp_tag = 0;
        bus.disp_v1 = 0; bus.disp_v2 = 0; bus.disp_q1 = 0; bus.disp_q2 = 0;
        bus.disp_rdy1 = 0; bus.disp_rdy2 = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    endtask

    task automatic set_disp(input logic [2:0] f3, input logic [5:0] tag, input logic [31:0] v1, input logic [31:0] v2,
                            input logic r1, input logic r2, input logic [5:0] q1, input logic [5:0] q2);
        bus.disp_valid = 1; bus.disp_funct3 = f3; bus.disp_tag = tag;
        bus.disp_v1 = v1; bus.disp_v2 = v2; bus.disp_rdy1 = r1; bus.disp_rdy2 = r2;
        bus.disp_q1 = q1; bus.disp_q2 = q2;
    endtask

    task automatic wait_next_qen(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.div_queue_en !== 1'b1 && n < max);
        chk("issue_seen", bus.div_queue_en, 1);
    endtask

    task automatic check_run(input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag, input logic [31:0] res);
        for (int c = 0; c < DIV_LAT; c++) begin
            tick();
            chk("hold_op1", bus.div_op1, a);
            chk("hold_op2", bus.div_op2, b);
        end
        chk("div_result_state", 32'(dstate), DIV_LAT);
        chk("div_result", div_ref(bus.div_funct3, bus.div_op1, bus.div_op2), res);
        chk("div_result_tag", bus.div_tag, tag);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [5:0]  tag;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [5:0]  tag, q1, q2;
        logic [31:0] v1, v2;
        bit          r1, r2;
    } ment_t;

    ment_t       mq[$];
    bit          m_idle, m_qen;
    int          m_cnt;
    logic [31:0] m_op1, m_op2;
    logic [2:0]  m_f3;
    logic [5:0]  m_tag;

    // Reference: oldest-ready pick from an ordered list, then CDB wakeup, then append.
    task automatic model_step();
        int    idx;
        bit    full, hit;
        ment_t e;
        idx   = -1;
        foreach (mq[i]) if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
        full  = (mq.size() == DEPTH);
        m_qen = 0;
        if (m_idle && !bus.div_busy && idx >= 0) begin
            m_qen  = 1;
            m_op1  = mq[idx].v1;
            m_op2  = mq[idx].v2;
            m_f3   = mq[idx].f3;
            m_tag  = mq[idx].tag;
            mq.delete(idx);
            m_idle = 0;
            m_cnt  = DIV_LAT;
        end else if (!m_idle) begin
            if (m_cnt == 1) m_idle = 1;
            m_cnt--;
        end
        hit = bus.cdb_valid && bus.cdb_tag != 0;
        foreach (mq[i]) begin
            if (!mq[i].r1 && hit && mq[i].q1 == bus.cdb_tag) begin mq[i].v1 = bus.cdb_data; mq[i].r1 = 1; end
            if (!mq[i].r2 && hit && mq[i].q2 == bus.cdb_tag) begin mq[i].v2 = bus.cdb_data; mq[i].r2 = 1; end
        end
        if (bus.disp_valid && !full) begin
            e.f3  = bus.disp_funct3;
            e.tag = bus.disp_tag;
            e.q1  = bus.disp_q1;
            e.q2  = bus.disp_q2;
            e.r1  = bus.disp_rdy1 || (hit && bus.disp_q1 == bus.cdb_tag);
            e.r2  = bus.disp_rdy2 || (hit && bus.disp_q2 == bus.cdb_tag);
            e.v1  = bus.disp_rdy1 ? bus.disp_v1 : bus.cdb_data;
            e.v2  = bus.disp_rdy2 ? bus.disp_v2 : bus.cdb_data;
            mq.push_back(e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   n;
        logic rdy_seen;
        int   seen;

        vecs[0] = '{3'd4, 32'd100,        32'd7,          6'd9,  32'd14};
        vecs[1] = '{3'd6, 32'd100,        32'd7,          6'd10, 32'd2};
        vecs[2] = '{3'd5, 32'hFFFFFFF0,   32'd3,          6'd11, 32'h55555550};
        vecs[3] = '{3'd4, 32'hFFFFFFF0,   32'd3,          6'd12, 32'hFFFFFFFB};
        vecs[4] = '{3'd6, 32'hFFFFFFF0,   32'd3,          6'd13, 32'hFFFFFFFF};
        vecs[5] = '{3'd4, 32'd5,          32'd0,          6'd14, 32'hFFFFFFFF};
        vecs[6] = '{3'd7, 32'd5,          32'd0,          6'd15, 32'd5};
        vecs[7] = '{3'd4, 32'h80000000,   32'hFFFFFFFF,   6'd16, 32'h80000000};

        clear_in();
        rst = 1;
        tick();
        tick();
        chk("rst_count", bus.count, 0);
        chk("rst_disp_ready", bus.disp_ready, 1);
        chk("rst_queue_en", bus.div_queue_en, 0);
        chk("rst_op1", bus.div_op1, 0);
        chk("rst_op2", bus.div_op2, 0);
        chk("rst_tag", bus.div_tag, 0);
        chk("rst_funct3", bus.div_funct3, 0);
        rst = 0;
        tick();

        // Single ready ops, one at a time through an empty station.
        for (int k = 0; k < 8; k++) begin
            set_disp(vecs[k].f3, vecs[k].tag, vecs[k].a, vecs[k].b, 1, 1, 0, 0);
            tick();
            clear_in();
            chk("vec_no_bypass", bus.div_queue_en, 0);
            tick();
            chk("vec_queue_en", bus.div_queue_en, 1);
            chk("vec_op1", bus.div_op1, vecs[k].a);
            chk("vec_op2", bus.div_op2, vecs[k].b);
            chk("vec_tag", bus.div_tag, vecs[k].tag);
            chk("vec_funct3", bus.div_funct3, vecs[k].f3);
            check_run(vecs[k].a, vecs[k].b, vecs[k].tag, vecs[k].res);
            tick();
        end

        // Back-to-back issue spacing.
        set_disp(3'd4, 6'd30, 32'd100, 32'd7, 1, 1, 0, 0);
        tick();
        set_disp(3'd7, 6'd31, 32'd100, 32'd7, 1, 1, 0, 0);
        tick();
        clear_in();
        chk("b2b_first_qen", bus.div_queue_en, 1);
        chk("b2b_first_tag", bus.div_tag, 30);
        check_run(32'd100, 32'd7, 6'd30, 32'd14);
        tick();
        chk("b2b_second_qen", bus.div_queue_en, 1);
        chk("b2b_second_tag", bus.div_tag, 31);
        check_run(32'd100, 32'd7, 6'd31, 32'd2);
        tick();

        // Older waiting entry is overtaken, then woken by the CDB.
        set_disp(3'd4, 6'd20, 32'd0, 32'd10, 0, 1, 6'd12, 0);
        tick();
        set_disp(3'd4, 6'd21, 32'd100, 32'd7, 1, 1, 0, 0);
        tick();
        clear_in();
        chk("wake_count", bus.count, 2);
        wait_next_qen(10, n);
        chk("wake_young_first", bus.div_tag, 21);
        bus.cdb_valid = 1; bus.cdb_tag = 6'd12; bus.cdb_data = 32'd50;
        tick();
        clear_in();
        wait_next_qen(20, n);
        chk("wake_spacing", n, 5);
        chk("wake_tag", bus.div_tag, 20);
        chk("wake_op1", bus.div_op1, 50);
        check_run(32'd50, 32'd10, 6'd20, 32'd5);
        tick();

        // Dispatch with same-cycle CDB forwarding.
        set_disp(3'd4, 6'd22, 32'd100, 32'd0, 1, 0, 0, 6'd20);
        bus.cdb_valid = 1; bus.cdb_tag = 6'd20; bus.cdb_data = 32'd5;
        tick();
        clear_in();
        chk("fwd_no_bypass", bus.div_queue_en, 0);
        tick();
        chk("fwd_qen", bus.div_queue_en, 1);
        chk("fwd_op2", bus.div_op2, 5);
        check_run(32'd100, 32'd5, 6'd22, 32'd20);
        tick();

        // Full station, simultaneous issue and dropped dispatch.
        set_disp(3'd5, 6'd40, 32'd100, 32'd7, 1, 1, 0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_disp(3'd5, 6'(41 + k), 32'(100 + k), 32'd7, 1, 1, 0, 0);
            tick();
        end
        clear_in();
        chk("full_count", bus.count, 4);
        chk("full_not_ready", bus.disp_ready, 0);
        rdy_seen = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_disp(3'd5, 6'd60, 32'd1, 32'd1, 1, 1, 0, 0);
            rdy_seen = bus.disp_ready;
            tick();
            if (bus.div_queue_en === 1'b1) break;
        end
        clear_in();
        chk("full_drop_ready", rdy_seen, 0);
        chk("full_issue_qen", bus.div_queue_en, 1);
        chk("full_issue_tag", bus.div_tag, 41);
        chk("full_count_after", bus.count, 3);
        chk("full_ready_after", bus.disp_ready, 1);
        for (int k = 0; k < 3; k++) begin
            wait_next_qen(20, n);
            chk("full_drain_tag", bus.div_tag, 42 + k);
        end
        chk("full_drained", bus.count, 0);

        // Asynchronous reset while running with entries held.
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 4; k++) begin
            set_disp(3'd4, 6'(50 + k), 32'd77, 32'd3, 1, 1, 0, 0);
            tick();
        end
        clear_in();
        #3;
        rst = 1;
        #1;
        chk("arst_qen", bus.div_queue_en, 0);
        chk("arst_op1", bus.div_op1, 0);
        chk("arst_op2", bus.div_op2, 0);
        chk("arst_count", bus.count, 0);
        chk("arst_ready", bus.disp_ready, 1);
        tick();
        @(negedge clk);
        rst = 0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.div_queue_en === 1'b1) seen++;
        end
        chk("arst_no_issue", seen, 0);
        set_disp(3'd5, 6'd54, 32'd9, 32'd2, 1, 1, 0, 0);
        tick();
        clear_in();
        tick();
        chk("arst_new_qen", bus.div_queue_en, 1);
        chk("arst_new_tag", bus.div_tag, 54);

        // Randomised traffic against the queue model.
        rst = 1;
        tick();
        tick();
        rst = 0;
        mq.delete();
        m_idle = 1; m_cnt = 0; m_qen = 0;
        m_op1 = 0; m_op2 = 0; m_f3 = 0; m_tag = 0;
        for (int c = 0; c < 800; c++) begin
            bus.disp_valid  = ($urandom_range(0, 99) < 60);
            bus.disp_funct3 = 3'(4 + $urandom_range(0, 3));
            bus.disp_tag    = 6'($urandom_range(1, 63));
            bus.disp_v1     = $urandom;
            bus.disp_v2     = $urandom;
            bus.disp_rdy1   = ($urandom_range(0, 2) != 0);
            bus.disp_rdy2   = ($urandom_range(0, 2) != 0);
            bus.disp_q1     = 6'($urandom_range(1, 6));
            bus.disp_q2     = 6'($urandom_range(1, 6));
            bus.cdb_valid   = ($urandom_range(0, 1) != 0);
            bus.cdb_tag     = 6'($urandom_range(0, 6));
            bus.cdb_data    = $urandom;
            model_step();
            tick();
            chk("rnd_qen", bus.div_queue_en, m_qen);
            chk("rnd_count", bus.count, mq.size());
            chk("rnd_ready", bus.disp_ready, (mq.size() < DEPTH));
            chk("rnd_op1", bus.div_op1, m_op1);
            chk("rnd_op2", bus.div_op2, m_op2);
            chk("rnd_funct3", bus.div_funct3, m_f3);
            chk("rnd_tag", bus.div_tag, m_tag);
        end
        clear_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
